// File: rtl/result_capture_if.sv
// result_capture_if: processor result buses in, captured-pair FIFO drain out.
interface result_capture_if #(parameter int DEPTH = 4);
  logic [31:0] V0, V1;
  logic OutReady, OutValid;
  logic [31:0] OutV0, OutV1;
  logic [$clog2(DEPTH):0] Count;
  logic Overflow;
  modport master (output V0, V1, OutReady, input OutValid, OutV0, OutV1, Count, Overflow);
  modport slave (input V0, V1, OutReady, output OutValid, OutV0, OutV1, Count, Overflow);
endinterface

// File: rtl/result_capture.sv
// result_capture: captures each new (v0,v1) pair once it has been stable, into a FWFT FIFO.
module result_capture #(
  parameter int STABLE_CYCLES = 8,
  parameter int DEPTH = 4,
  parameter bit SKIP_ZERO = 1
) (
  input logic Clk,
  input logic Reset,
  result_capture_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic {TRACK, HOLD} state_t;
  state_t state_q, state_d;
  logic [63:0] s_q, s_d, last_q, last_d;
  logic last_vld_q, last_vld_d;
  logic [7:0] cnt_q, cnt_d;
  logic [63:0] mem_q [DEPTH];
  logic [63:0] mem_d [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic ovf_q, ovf_d;
  logic match, push, pop, acc, valid;
  always_comb begin
    s_d = {bus.V0, bus.V1};
    match = s_d == s_q;
    state_d = state_q;
    cnt_d = cnt_q;
    push = 1'b0;
    if (!match) begin
      state_d = TRACK;
      cnt_d = '0;
    end else if (state_q == TRACK && cnt_q == 8'(STABLE_CYCLES - 1)) begin
      state_d = HOLD;
      push = !(last_vld_q && s_q == last_q) && !(SKIP_ZERO && s_q == '0);
    end else if (state_q == TRACK) begin
      cnt_d = cnt_q + 8'd1;
    end
    last_d = push ? s_q : last_q;
    last_vld_d = last_vld_q | push;
  end
  // A full FIFO still accepts a push when the head leaves on the same edge.
  always_comb begin
    valid = count_q != '0;
    pop = valid & bus.OutReady;
    acc = push & ((count_q != CW'(DEPTH)) | pop);
    mem_d = mem_q;
    if (acc) mem_d[wptr_q] = s_q;
    wptr_d = wptr_q + AW'(acc);
    rptr_d = rptr_q + AW'(pop);
    count_d = count_q + CW'(acc) - CW'(pop);
    ovf_d = ovf_q | (push & ~acc);
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= TRACK;
      s_q <= '0;
      cnt_q <= '0;
      last_q <= '0;
      last_vld_q <= 1'b0;
      mem_q <= '{default: '0};
      wptr_q <= '0;
      rptr_q <= '0;
      count_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q <= s_d;
      cnt_q <= cnt_d;
      last_q <= last_d;
      last_vld_q <= last_vld_d;
      mem_q <= mem_d;
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      count_q <= count_d;
      ovf_q <= ovf_d;
    end
  end
  assign bus.OutValid = valid;
  assign {bus.OutV0, bus.OutV1} = mem_q[rptr_q];
  assign bus.Count = count_q;
  assign bus.Overflow = ovf_q;
endmodule

// File: tb/tb_result_capture.sv
// tb_result_capture: randomized + directed stimulus, behavioural model feeding a scoreboard queue.
module tb_result_capture;
  localparam int SC = 8;
  localparam int DEPTH = 4;
  localparam bit SKIP_ZERO = 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  result_capture_if #(.DEPTH(DEPTH)) bus ();
  result_capture #(.STABLE_CYCLES(SC), .DEPTH(DEPTH), .SKIP_ZERO(SKIP_ZERO)) dut (
    .Clk(clk),
    .Reset(rst),
    .bus(bus)
  );
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] prev_in, last_cap, cur_in;
  bit last_vld, ovf_m, started, pop_m;
  int run, occ;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: a pair is captured once it has been seen unchanged on SC+1 consecutive edges.
  initial forever begin
    @(posedge clk);
    started = 1;
    cur_in = {bus.V0, bus.V1};
    if (rst) begin
      exp_q.delete();
      occ = 0; ovf_m = 0; last_vld = 0; last_cap = '0; prev_in = '0; run = 0;
    end else begin
      pop_m = occ > 0 && bus.OutReady;
      run = (cur_in == prev_in) ? ((run < 100000) ? run + 1 : run) : 0;
      prev_in = cur_in;
      if (run == SC && !(last_vld && cur_in == last_cap) && !(SKIP_ZERO && cur_in == '0)) begin
        last_cap = cur_in;
        last_vld = 1;
        if (occ < DEPTH || pop_m) begin
          exp_q.push_back(cur_in);
          occ++;
        end else ovf_m = 1;
      end
      if (pop_m) occ--;
    end
  end

  initial forever begin
    @(negedge clk);
    if (started) begin
      check("count", 64'(bus.Count), 64'(occ));
      check("overflow", 64'(bus.Overflow), 64'(ovf_m));
      check("valid", 64'(bus.OutValid), 64'(occ != 0));
      if (bus.OutValid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL head: valid with head %0h but no expected entry", {bus.OutV0, bus.OutV1});
        end else begin
          check("head", {bus.OutV0, bus.OutV1}, exp_q[0]);
          if (bus.OutReady) void'(exp_q.pop_front());
        end
      end
    end
  end

  task automatic set(input logic [31:0] a, input logic [31:0] b, input logic rdy);
    bus.V0 = a; bus.V1 = b; bus.OutReady = rdy;
  endtask
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic hold(input logic [31:0] a, input logic [31:0] b, input logic rdy, input int n);
    set(a, b, rdy);
    step(n);
  endtask

  initial begin
    int e;
    set(0, 0, 0);
    rst = 1;
    step(7);
    check("reset_outv", {bus.OutV0, bus.OutV1}, 64'h0);
    check("reset_count", 64'(bus.Count), 64'h0);
    rst = 0;
    step(50);
    check("zero_skip_count", 64'(bus.Count), 64'h0);
    check("zero_skip_valid", 64'(bus.OutValid), 64'h0);
    set(32'h12, 32'h34, 0);
    e = 0;
    while (!bus.OutValid && e < 20) begin
      step(1);
      e++;
    end
    check("latency", 64'(e - 1), 64'(SC));
    check("first_pair", {bus.OutV0, bus.OutV1}, {32'h12, 32'h34});
    check("first_count", 64'(bus.Count), 64'h1);
    hold(32'h12, 32'h34, 1, 3);
    for (int i = 0; i < 5; i++) begin
      hold(1, 2, 0, 3);
      hold(3, 4, 0, 3);
    end
    check("toggle_count", 64'(bus.Count), 64'h0);
    hold(3, 4, 0, 20);
    check("toggle_hold_count", 64'(bus.Count), 64'h1);
    check("toggle_hold_pair", {bus.OutV0, bus.OutV1}, {32'h3, 32'h4});
    hold(3, 4, 1, 3);
    hold(5, 6, 0, 10);
    hold(7, 8, 0, 10);
    hold(5, 6, 0, 10);
    check("aba_count", 64'(bus.Count), 64'h3);
    hold(5, 6, 1, 4);
    for (int i = 0; i < 5; i++) hold(32'h100 + i, 32'h200 + i, 0, 10);
    check("ovf_count", 64'(bus.Count), 64'h4);
    check("ovf_flag", 64'(bus.Overflow), 64'h1);
    check("ovf_head", {bus.OutV0, bus.OutV1}, {32'h100, 32'h200});
    hold(32'h104, 32'h204, 1, 4);
    check("drain_count", 64'(bus.Count), 64'h0);
    rst = 1;
    step(1);
    rst = 0;
    for (int i = 0; i < 4; i++) hold(32'h300 + i, 32'h310 + i, 0, 10);
    set(32'h400, 32'h500, 0);
    step(SC);
    bus.OutReady = 1;
    step(1);
    bus.OutReady = 0;
    check("full_pushpop_count", 64'(bus.Count), 64'h4);
    check("full_pushpop_ovf", 64'(bus.Overflow), 64'h0);
    check("full_pushpop_head", {bus.OutV0, bus.OutV1}, {32'h301, 32'h311});
    hold(32'h600, 32'h700, 0, 12);
    check("ovf_again", 64'(bus.Overflow), 64'h1);
    bus.OutReady = 1;
    step(1);
    bus.OutReady = 0;
    check("pre_reset_count", 64'(bus.Count), 64'h3);
    rst = 1;
    step(1);
    check("mid_reset_count", 64'(bus.Count), 64'h0);
    check("mid_reset_valid", 64'(bus.OutValid), 64'h0);
    check("mid_reset_ovf", 64'(bus.Overflow), 64'h0);
    rst = 0;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        rst = 1;
        step(1);
        rst = 0;
      end
      hold($urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom_range(0, 1)),
           $urandom_range(1, 12));
    end
    hold(32'hdead, 32'hbeef, 1, DEPTH + 2);
    check("final_queue_empty", 64'(exp_q.size()), 64'h0);
    check("final_count", 64'(bus.Count), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
